// File: rtl/spi_flash_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_flash_arbiter: sequenced CPU/programmer handover of the shared flash.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module spi_flash_arbiter #(
    parameter int GUARD_CYCLES  = 4,
    parameter int DRAIN_TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic i_FT_CS,
    input  logic i_ctrl_spi_clk,
    input  logic i_ctrl_spi_mosi,
    input  logic i_ctrl_spi_cs,
    input  logic i_wr_spi_clk,
    input  logic i_wr_spi_mosi,
    input  logic i_wr_spi_cs,
    output logic o_SPI_CLK,
    output logic o_SPI_MOSI,
    output logic o_SPI_CS,
    output logic o_HALT,
    output logic o_cpu_grant,
    output logic o_prog_grant,
    output logic o_abort
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CPU     = 3'd1,
        ST_DRAIN   = 3'd2,
        ST_GUARD_P = 3'd3,
        ST_PROG    = 3'd4,
        ST_GUARD_C = 3'd5
    } state_t;

    localparam logic [7:0] c_guard_last = 8'(GUARD_CYCLES - 1);
    localparam logic [7:0] c_drain_last = 8'(DRAIN_TIMEOUT);

    logic [1:0] r_ft_cs_sync;
    logic       w_req;
    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_next;
    logic       w_count_en;
    logic       w_abort;
    logic       r_cpu_grant;
    logic       r_prog_grant;
    logic       r_halt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ft_cs_sync <= 2'b11;
        end else begin
            r_ft_cs_sync <= {r_ft_cs_sync[0], i_FT_CS};
        end
    end

    assign w_req = ~r_ft_cs_sync[1];

    always_comb begin
        w_state_next = r_state;
        w_count_en   = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            ST_IDLE:    w_state_next = w_req ? ST_GUARD_P : ST_CPU;
            ST_CPU:     if (w_req) w_state_next = ST_DRAIN;
            ST_DRAIN: begin
                // A dropped request or a clean CS release both take precedence over the cut.
                if (!w_req) begin
                    w_state_next = ST_CPU;
                end else if (i_ctrl_spi_cs) begin
                    w_state_next = ST_GUARD_P;
                end else if (r_cnt == c_drain_last) begin
                    w_abort      = 1'b1;
                    w_state_next = ST_GUARD_P;
                end else begin
                    w_count_en = 1'b1;
                end
            end
            ST_GUARD_P: begin
                if (!w_req) begin
                    w_state_next = ST_CPU;
                end else if (r_cnt == c_guard_last) begin
                    w_state_next = ST_PROG;
                end else begin
                    w_count_en = 1'b1;
                end
            end
            ST_PROG:    if (!w_req) w_state_next = ST_GUARD_C;
            ST_GUARD_C: begin
                if (w_req) begin
                    w_state_next = ST_GUARD_P;
                end else if (r_cnt == c_guard_last) begin
                    w_state_next = ST_CPU;
                end else begin
                    w_count_en = 1'b1;
                end
            end
            default:    w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_cnt_next = r_cnt;
        if (w_state_next != r_state) begin
            w_cnt_next = 8'd0;
        end else if (w_count_en && (r_cnt != 8'hFF)) begin
            w_cnt_next = r_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 8'd0;
            r_cpu_grant  <= 1'b0;
            r_prog_grant <= 1'b0;
            r_halt       <= 1'b1;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_cpu_grant  <= (w_state_next == ST_CPU);
            r_prog_grant <= (w_state_next == ST_PROG);
            r_halt       <= (w_state_next == ST_IDLE) || (w_state_next == ST_CPU);
        end
    end

    // Pure mux on the registered state keeps each master's SPI timing untouched.
    always_comb begin
        o_SPI_CS   = 1'b1;
        o_SPI_CLK  = 1'b0;
        o_SPI_MOSI = 1'b0;
        case (r_state)
            ST_CPU, ST_DRAIN: begin
                o_SPI_CS   = i_ctrl_spi_cs;
                o_SPI_CLK  = i_ctrl_spi_clk;
                o_SPI_MOSI = i_ctrl_spi_mosi;
            end
            ST_PROG: begin
                o_SPI_CS   = i_wr_spi_cs;
                o_SPI_CLK  = i_wr_spi_clk;
                o_SPI_MOSI = i_wr_spi_mosi;
            end
            default: ;
        endcase
    end

    assign o_cpu_grant  = r_cpu_grant;
    assign o_prog_grant = r_prog_grant;
    assign o_HALT       = r_halt;
    assign o_abort      = w_abort;

endmodule
`default_nettype wire
